// File: rtl/button_event_decoder.sv
// Turns a debounced button level into single-cycle gesture events:
// press, release, click, double-click, long-press and auto-repeat.
module button_event_decoder #(
   parameter int unsigned LONG_CYCLES   = 20,
   parameter int unsigned DCLICK_GAP    = 8,
   parameter int unsigned REPEAT_CYCLES = 5
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic press,
   output logic release_p,
   output logic click,
   output logic double_click,
   output logic long_press,
   output logic rpt,
   output logic held
);

   localparam int unsigned MAX_CYC =
      (LONG_CYCLES > DCLICK_GAP)
         ? ((LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES)
         : ((DCLICK_GAP > REPEAT_CYCLES) ? DCLICK_GAP : REPEAT_CYCLES);
   localparam int unsigned CNT_W = $clog2(MAX_CYC + 1);

   localparam logic [CNT_W-1:0] CNT_SAT = '1;
   localparam logic [CNT_W-1:0] LONG_M2 = CNT_W'(LONG_CYCLES - 2);
   localparam logic [CNT_W-1:0] GAP_M1  = CNT_W'(DCLICK_GAP - 1);
   localparam logic [CNT_W-1:0] RPT_M1  = CNT_W'(REPEAT_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE,
      PRESSED,
      LONG,
      WAIT_GAP,
      SECOND
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic             btn_q;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             rise;
   logic             fall;
   logic             click_nxt;
   logic             dclick_nxt;
   logic             long_nxt;
   logic             rpt_nxt;
   logic             held_nxt;
   logic             cnt_reload;

   assign rise = btn & ~btn_q;
   assign fall = ~btn & btn_q;

   // State, counter and all registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         btn_q        <= 1'b0;
         cnt          <= '0;
         press        <= 1'b0;
         release_p    <= 1'b0;
         click        <= 1'b0;
         double_click <= 1'b0;
         long_press   <= 1'b0;
         rpt          <= 1'b0;
         held         <= 1'b0;
      end else begin
         state        <= state_nxt;
         btn_q        <= btn;
         cnt          <= cnt_nxt;
         press        <= rise;
         release_p    <= fall;
         click        <= click_nxt;
         double_click <= dclick_nxt;
         long_press   <= long_nxt;
         rpt          <= rpt_nxt;
         held         <= held_nxt;
      end
   end

   // Gesture decode: next state, event pulses and counter update
   always_comb begin
      state_nxt  = state;
      click_nxt  = 1'b0;
      dclick_nxt = 1'b0;
      long_nxt   = 1'b0;
      rpt_nxt    = 1'b0;
      cnt_reload = 1'b0;

      case (state)
         IDLE: begin
            if (rise) state_nxt = PRESSED;
         end
         PRESSED, SECOND: begin
            if (fall) begin
               state_nxt  = (state == PRESSED) ? WAIT_GAP : IDLE;
               dclick_nxt = (state == SECOND);
            end else if (cnt == LONG_M2) begin
               state_nxt = LONG;
               long_nxt  = 1'b1;
            end
         end
         LONG: begin
            // A release always suppresses a coincident repeat pulse
            if (fall) begin
               state_nxt = IDLE;
            end else if (cnt == RPT_M1) begin
               rpt_nxt    = 1'b1;
               cnt_reload = 1'b1;
            end
         end
         WAIT_GAP: begin
            if (rise) begin
               state_nxt = SECOND;
            end else if (cnt == GAP_M1) begin
               state_nxt = IDLE;
               click_nxt = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase

      held_nxt = (state_nxt == PRESSED) || (state_nxt == LONG) || (state_nxt == SECOND);

      if ((state_nxt != state) || cnt_reload) begin
         cnt_nxt = '0;
      end else if (cnt != CNT_SAT) begin
         cnt_nxt = cnt + CNT_W'(1);
      end else begin
         cnt_nxt = cnt;
      end
   end

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed, table-driven bench for button_event_decoder with hand-computed
// per-cycle expectations on all seven outputs.
module tb_button_event_decoder;

   localparam logic [6:0] E_P  = 7'b1000000;
   localparam logic [6:0] E_R  = 7'b0100000;
   localparam logic [6:0] E_C  = 7'b0010000;
   localparam logic [6:0] E_D  = 7'b0001000;
   localparam logic [6:0] E_L  = 7'b0000100;
   localparam logic [6:0] E_RP = 7'b0000010;
   localparam logic [6:0] E_H  = 7'b0000001;
   localparam logic [6:0] E_0  = 7'b0000000;

   logic clk = 1'b0;
   logic rst;
   logic btn;
   logic press;
   logic release_p;
   logic click;
   logic double_click;
   logic long_press;
   logic rpt;
   logic held;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       rst;
      logic       btn;
      logic [6:0] exp;
      int         grp;
   } vec_t;

   vec_t  vecs[$];
   string gname[4] = '{"reset_idle", "short_click", "double_click", "long_repeat"};

   always #5 clk = ~clk;

   button_event_decoder #(
      .LONG_CYCLES  (20),
      .DCLICK_GAP   (8),
      .REPEAT_CYCLES(5)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .btn         (btn),
      .press       (press),
      .release_p   (release_p),
      .click       (click),
      .double_click(double_click),
      .long_press  (long_press),
      .rpt         (rpt),
      .held        (held)
   );

   function automatic void add(input logic r, input logic b, input logic [6:0] e,
                               input int n, input int g);
      for (int i = 0; i < n; i++) vecs.push_back('{r, b, e, g});
   endfunction

   // Drive one cycle of inputs, then compare all outputs just after the edge
   task automatic step(input logic r, input logic b, input logic [6:0] e, input string tag);
      logic [6:0] got;
      rst = r;
      btn = b;
      @(posedge clk);
      #1;
      got = {press, release_p, click, double_click, long_press, rpt, held};
      checks++;
      if (got !== e) begin
         errors++;
         $display("FAIL %s check %0d: got {p,r,c,d,l,rpt,h}=%b expected %b",
                  tag, checks, got, e);
      end
   endtask

   initial begin
      rst = 1'b1;
      btn = 1'b0;

      // Reset, then a long idle stretch
      add(1, 0, E_0, 2, 0);
      add(0, 0, E_0, 50, 0);

      // Short press of 5 cycles; click 8 edges after release_p
      add(0, 1, E_P | E_H, 1, 1);
      add(0, 1, E_H, 4, 1);
      add(0, 0, E_R, 1, 1);
      add(0, 0, E_0, 7, 1);
      add(0, 0, E_C, 1, 1);
      add(0, 0, E_0, 5, 1);

      // 3 high, 3 low, 3 high, low: double_click with the second release
      add(0, 1, E_P | E_H, 1, 2);
      add(0, 1, E_H, 2, 2);
      add(0, 0, E_R, 1, 2);
      add(0, 0, E_0, 2, 2);
      add(0, 1, E_P | E_H, 1, 2);
      add(0, 1, E_H, 2, 2);
      add(0, 0, E_R | E_D, 1, 2);
      add(0, 0, E_0, 16, 2);

      // 40-cycle hold: long_press on 20th edge, repeats every 5 after
      add(0, 1, E_P | E_H, 1, 3);
      add(0, 1, E_H, 18, 3);
      add(0, 1, E_L | E_H, 1, 3);
      for (int k = 0; k < 4; k++) begin
         add(0, 1, E_H, 4, 3);
         add(0, 1, E_RP | E_H, 1, 3);
      end
      add(0, 0, E_R, 1, 3);
      add(0, 0, E_0, 12, 3);

      for (int i = 0; i < vecs.size(); i++)
         step(vecs[i].rst, vecs[i].btn, vecs[i].exp, gname[vecs[i].grp]);

      // Second rise exactly on the gap-expiry edge: SECOND wins, no click
      step(0, 1, E_P | E_H, "gap_edge_press");
      step(0, 1, E_H, "gap_edge_hold");
      step(0, 0, E_R, "gap_edge_release");
      for (int i = 0; i < 7; i++) step(0, 0, E_0, "gap_edge_wait");
      step(0, 1, E_P | E_H, "gap_edge_rise");
      step(0, 1, E_H, "gap_edge_second_held");
      step(0, 0, E_R | E_D, "gap_edge_double");
      for (int i = 0; i < 10; i++) step(0, 0, E_0, "gap_edge_quiet");

      // Reset in the middle of a hold, button still high across reset
      step(0, 1, E_P | E_H, "rst_mid_press");
      for (int i = 0; i < 9; i++) step(0, 1, E_H, "rst_mid_hold");
      step(1, 1, E_0, "rst_mid_in_reset");
      step(1, 1, E_0, "rst_mid_in_reset");
      step(0, 1, E_P | E_H, "rst_mid_repress");
      for (int i = 0; i < 18; i++) step(0, 1, E_H, "rst_mid_rehold");
      step(0, 1, E_L | E_H, "rst_mid_long");
      for (int i = 0; i < 3; i++) step(0, 1, E_H, "rst_mid_long_held");
      step(0, 0, E_R, "rst_mid_release");
      for (int i = 0; i < 10; i++) step(0, 0, E_0, "rst_mid_quiet");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
